// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter and its slaves.
// Holds the arbiter state encoding, default bus widths and slave base nibbles.
// No logic of its own apart from the round-robin tie helper.
package mem_bus_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Upper address nibble selecting each slave on the bus.
    localparam logic [3:0] BASE_INST = 4'h0;
    localparam logic [3:0] BASE_LED  = 4'h1;
    localparam logic [3:0] BASE_SEG7 = 4'h2;
    localparam logic [3:0] BASE_SW   = 4'h3;
    localparam logic [3:0] BASE_KEY  = 4'h4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // On a tie the master that did not own the bus most recently wins.
    function automatic state_t rr_pick(input logic last);
        return last ? OWN0 : OWN1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin, grant-holding two-master arbiter for the 16-bit memory bus.
// Latency: grant 1 cycle after request from IDLE; read data valid 1 cycle after the read.
// Backpressure: a requester without grant holds its request stable; ARB_TIMEOUT_EN adds owner preemption.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          we1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DOUT,
    output logic          W,
    input  logic [DW-1:0] DIN
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mem_bus_arbiter: MAX_HOLD must be within 1..255");
    end

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   rvalid0_q, rvalid0_d;
    logic   rvalid1_q, rvalid1_d;
    logic   xfer0, xfer1;
    logic   expire;

    assign xfer0 = (state_q == OWN0) & req0;
    assign xfer1 = (state_q == OWN1) & req1;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [7:0] hold_q, hold_d;
    logic       other_req;

    // The waiting master's request, as seen from the current owner.
    always_comb begin
        other_req = 1'b0;
        if (state_q == OWN0) begin
            other_req = req1;
        end else if (state_q == OWN1) begin
            other_req = req0;
        end
    end

    // Current owned cycle is the MAX_HOLD-th one with the other side waiting.
    assign expire = other_req && (hold_q >= HOLD_MAX - 8'd1);

    // Count contested owned cycles; restart on any grant change or uncontested cycle.
    always_comb begin
        hold_d = hold_q;
        if ((state_d != state_q) || !other_req) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Ownership decision: tie by round-robin, direct handover with no idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = rr_pick(last_q);
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0 || expire) begin
                    state_d = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!req1 || expire) begin
                    state_d = req0 ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remember the most recent owner, and flag reads that return next cycle.
    always_comb begin
        last_d = last_q;
        if (state_d == OWN0) begin
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
        end
        rvalid0_d = xfer0 & ~we0;
        rvalid1_d = xfer1 & ~we1;
    end

    // State, priority pointer and read-return flags.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Drive the bus from the owner only while it is actually requesting.
    always_comb begin
        ADDR = '0;
        DOUT = '0;
        W    = 1'b0;
        if (xfer0) begin
            ADDR = addr0;
            DOUT = wdata0;
            W    = we0;
        end else if (xfer1) begin
            ADDR = addr1;
            DOUT = wdata1;
            W    = we1;
        end
    end

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = DIN;

endmodule
